// File: rtl/counter_bcd_seq_pkg.sv
// Shared types and helpers for the preloadable counter and its sequential
// binary-to-BCD converter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Double-dabble correction: a nibble of 5..9 gets 3 added before the shift.
  function automatic logic [3:0] bcd_adj3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

  // 10^n for elaboration-time range checks.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/counter_bcd_seq_conv.sv
// Sequential double-dabble converter: one shift per clock, WIDTH shifts per
// conversion, result published in a single DONE cycle so bcd never shows
// intermediate shift-register contents.
module bcd_seq_conv
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = BW + WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  conv_state_t   state;
  logic [SW-1:0] sr;
  logic [SW-1:0] sr_adj;
  logic [CW-1:0] bit_cnt;

  // Add-3 correction on every BCD nibble of the current register value.
  always_comb begin
    sr_adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++)
      sr_adj[WIDTH + 4*d +: 4] = bcd_adj3(sr[WIDTH + 4*d +: 4]);
  end

  // Converter FSM; done is high for the DONE cycle, i.e. it marks the edge
  // on which bcd is published.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= {{BW{1'b0}}, bin};
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sr      <= sr_adj << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          bcd   <= sr[SW-1 -: BW];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_bcd_seq.sv
// Up/down counter with preload and wrap/saturate mode, feeding a sequential
// BCD converter that re-runs whenever the count differs from the last
// converted snapshot.
module counter_bcd_seq
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld,
  input  logic                  dir,
  input  logic                  sat,
  input  logic [WIDTH-1:0]      v,
  output logic [WIDTH-1:0]      count,
  output logic                  wrap,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  bcd_valid
);

  localparam logic [WIDTH-1:0] MAXV = '1;

  if (!(pow10(DIGITS) > ((longint'(1) << WIDTH) - 1))) begin : g_digits_check
    $error("DIGITS too small to represent 2^WIDTH-1");
  end

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] snap;
  logic             first;
  logic             start_pending;
  logic             conv_busy;
  logic             conv_done;

  // Next count: preload beats enable; limits either hold or wrap.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (ld) begin
      count_nxt = v;
    end else if (en) begin
      if (dir) begin
        if (count == MAXV) begin
          if (!sat) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          if (!sat) begin
            count_nxt = MAXV;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = count - 1'b1;
        end
      end
    end
  end

  // Count and wrap pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign start_pending = first | (count != snap);

  // Snapshot capture: mirrors the converter accepting start in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap  <= '0;
      first <= 1'b1;
    end else if (!conv_busy && start_pending) begin
      snap  <= count;
      first <= 1'b0;
    end
  end

  // bcd_valid: a count change always wins, then completion, then a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_valid <= 1'b0;
    end else if (count_nxt != count) begin
      bcd_valid <= 1'b0;
    end else if (conv_done) begin
      bcd_valid <= (snap == count);
    end else if (!conv_busy && start_pending) begin
      bcd_valid <= 1'b0;
    end
  end

  bcd_seq_conv #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_pending),
    .bin   (count),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign busy = conv_busy;

endmodule

// File: tb/tb_counter_bcd_seq.sv
// Bench for counter_bcd_seq (WIDTH=8, DIGITS=3): counter vector table,
// directed multi-cycle sequences, then random stimulus against a decimal
// reference model.
module tb_counter_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int MAXV   = (1 << WIDTH) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              ld  = 1'b0;
  logic              dir = 1'b1;
  logic              sat = 1'b0;
  logic [WIDTH-1:0]  v   = '0;
  logic [WIDTH-1:0]  count;
  logic              wrap;
  logic [4*DIGITS-1:0] bcd;
  logic              busy;
  logic              bcd_valid;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_count, m_bcd, m_snap, m_left;
  bit m_wrap, m_valid, m_busy, m_first;

  counter_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .dir(dir), .sat(sat), .v(v),
    .count(count), .wrap(wrap), .bcd(bcd), .busy(busy), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  function automatic int to_bcd(input int x);
    int r;
    r = 0;
    for (int d = 0; d < DIGITS; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  // One clock edge of the behavioural model, from the inputs presented.
  task automatic model_edge();
    int nc;
    bit nw;
    if (rst) begin
      m_count = 0; m_wrap = 0; m_bcd = 0; m_valid = 0; m_busy = 0;
      m_first = 1; m_left = 0; m_snap = 0;
      return;
    end
    nc = m_count; nw = 0;
    if (ld) nc = int'(v);
    else if (en && dir) begin
      if (m_count == MAXV) begin if (!sat) begin nc = 0; nw = 1; end end
      else nc = m_count + 1;
    end else if (en) begin
      if (m_count == 0) begin if (!sat) begin nc = MAXV; nw = 1; end end
      else nc = m_count - 1;
    end
    if (m_left == 0) begin
      if (m_first || m_count != m_snap) begin
        m_snap = m_count; m_first = 0; m_left = WIDTH + 1; m_valid = 0;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_bcd = to_bcd(m_snap);
        if (m_count == m_snap) m_valid = 1;
      end
    end
    if (nc != m_count) m_valid = 0;
    m_busy  = (m_left != 0);
    m_count = nc;
    m_wrap  = nw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (bcd_valid === 1'b1) break;
      step();
    end
    chk(nm, 32'(bcd_valid), 32'd1);
  endtask

  task automatic load(input int val);
    ld = 1'b1; en = 1'b0; v = WIDTH'(val);
    step();
    ld = 1'b0;
  endtask

  typedef struct {
    logic ld, en, dir, sat;
    logic [WIDTH-1:0] v;
    int exp_count;
    logic exp_wrap;
  } cvec_t;

  cvec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   0,   1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   255, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   254, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   255, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   0,   1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd10,  10,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   11,  1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   0,   1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   1,   1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 255, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   255, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   0,   1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1'b0};

    // reset state
    rst = 1'b1;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);

    // first conversion after reset: busy for 9 cycles, valid from edge 10
    rst = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      chk($sformatf("pwr_busy_e%0d", i), 32'(busy), (i <= 9) ? 32'd1 : 32'd0);
      chk($sformatf("pwr_valid_e%0d", i), 32'(bcd_valid), (i >= 10) ? 32'd1 : 32'd0);
    end
    chk("pwr_bcd", 32'(bcd), 32'h000);

    // load 255: bcd=255 and valid exactly 10 edges later
    load(255);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("ld255_count", 32'(count), 32'd255);
      chk($sformatf("ld255_valid_e%0d", i), 32'(bcd_valid), (i == 10) ? 32'd1 : 32'd0);
    end
    chk("ld255_bcd", 32'(bcd), 32'h255);

    // counter vector table
    rst = 1'b1; step(); rst = 1'b0;
    foreach (tbl[i]) begin
      ld = tbl[i].ld; en = tbl[i].en; dir = tbl[i].dir; sat = tbl[i].sat; v = tbl[i].v;
      step();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].exp_wrap));
    end
    ld = 1'b0; en = 1'b0;

    // 250 counting up with wrap
    wait_valid("pre250_settle");
    load(250);
    en = 1'b1; dir = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("up250_count%0d", i), 32'(count), 32'((250 + i) % 256));
      chk($sformatf("up250_wrap%0d", i), 32'(wrap), (i == 6) ? 32'd1 : 32'd0);
      chk($sformatf("up250_busy%0d", i), 32'(busy), 32'd1);
    end
    en = 1'b0;
    step();
    chk("up250_wrap_clear", 32'(wrap), 32'd0);
    wait_valid("up250_settle");
    chk("up250_bcd", 32'(bcd), 32'h000);

    // saturation at both limits
    load(255);
    en = 1'b1; dir = 1'b1; sat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_hi_count", 32'(count), 32'd255);
      chk("sat_hi_wrap", 32'(wrap), 32'd0);
    end
    load(0);
    en = 1'b1; dir = 1'b0; sat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_lo_count", 32'(count), 32'd0);
      chk("sat_lo_wrap", 32'(wrap), 32'd0);
    end
    en = 1'b0;

    // load 99 then 128 mid-conversion: stale 099 first, then 128
    wait_valid("pre99_settle");
    load(99);
    step(); step();
    load(128);
    for (int k = 4; k <= 20; k++) begin
      step();
      chk($sformatf("mid_valid_k%0d", k), 32'(bcd_valid), (k == 20) ? 32'd1 : 32'd0);
      if (k == 10) chk("mid_bcd099", 32'(bcd), 32'h099);
      if (k == 19) chk("mid_bcd099_hold", 32'(bcd), 32'h099);
      if (k == 20) chk("mid_bcd128", 32'(bcd), 32'h128);
    end

    // reset during a conversion of 200
    load(200);
    step(); step(); step();
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_bcd", 32'(bcd), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_valid", 32'(bcd_valid), 32'd0);
    wait_valid("rstmid_settle");
    chk("rstmid_bcd_after", 32'(bcd), 32'h000);

    // randomized stimulus against the reference model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) != 0);
      dir = $urandom_range(0, 1) == 1;
      sat = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: v = WIDTH'(MAXV);
        1: v = '0;
        default: v = WIDTH'($urandom_range(0, MAXV));
      endcase
      // occasionally hold still so conversions can complete
      if ($urandom_range(0, 2) == 0) begin en = 1'b0; ld = 1'b0; end
      step();
      chk("rnd_count", 32'(count), 32'(m_count));
      chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
      chk("rnd_busy", 32'(busy), 32'(m_busy));
      chk("rnd_valid", 32'(bcd_valid), 32'(m_valid));
      chk("rnd_bcd", 32'(bcd), 32'(m_bcd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_bcd_seq.md
Name: counter_bcd_seq

Overview:
- Parametrised successor to the preloadable counter + combinational BCD decoder pair.
- Contains an up/down counter with preload and a wrap/saturate mode.
- Adds a multi-cycle, sequential double-dabble binary-to-BCD converter with busy/valid status, replacing the wide combinational decoder.
- Feeds the board's 7-segment driver; the BCD output is glitch-free and only changes on conversion completion.

Parameters:
- WIDTH, 8, counter width in bits.
- DIGITS, 3, BCD digits produced. Elaboration-time assertion: 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  count enable
- ld  in  1  preload strobe, loads v
- dir  in  1  1 = count up, 0 = count down
- sat  in  1  1 = saturate at limits, 0 = wrap modulo 2^WIDTH
- v  in  WIDTH  preload value
- count  out  WIDTH  current count (registered)
- wrap  out  1  one-cycle pulse when count wraps (sat=0 only)
- bcd  out  4*DIGITS  BCD of last converted value; digit 0 is in bits [3:0]
- busy  out  1  conversion in progress
- bcd_valid  out  1  bcd equals current count and no conversion is pending

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, wrap=0, bcd=0, busy=0, bcd_valid=0.
  - FSM goes to IDLE; internal start_pending=1, so a conversion runs right after reset.
- Counter, evaluated every edge, priority ld > en:
  - ld=1: count <= v.
  - Else en=1, dir=1: at 2^WIDTH-1, count holds if sat=1, else goes to 0 with wrap=1. Otherwise count+1.
  - Else en=1, dir=0: at 0, count holds if sat=1, else goes to 2^WIDTH-1 with wrap=1. Otherwise count-1.
  - en=0, ld=0: count holds.
  - wrap is 0 in every other cycle, including ld cycles.
- Change detect:
  - snap holds the value captured at the last conversion start.
  - start_pending = first-after-reset flag OR (count != snap).
- Converter FSM states:
  - IDLE:
    - If start_pending: snap <= count; shift register <= {DIGITS*4 zeros, count}; bit counter <= 0; go to SHIFT.
    - Else remain in IDLE.
  - SHIFT, exactly WIDTH cycles. Each edge:
    - Every BCD nibble >= 5 has 3 added (combinationally, from the current register value).
    - The register then shifts left by 1.
    - After the WIDTH-th shift, go to DONE.
  - DONE, one cycle: bcd <= BCD nibbles; go to IDLE.
- Latency: bcd updates WIDTH+2 edges after the IDLE cycle that sampled the count (10 edges for WIDTH=8).
- Count changes during SHIFT/DONE:
  - The conversion completes using snap.
  - The next IDLE cycle sees count != snap and restarts immediately.
  - Stale results are always written, never aborted.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- bcd_valid:
  - Registered.
  - Set to 1 on the DONE→IDLE edge if snap == count at that edge.
  - Cleared on any edge where count changes value.
  - 0 while busy.
- bcd never shows partial shift-register contents.
- Reset mid-conversion discards the shift register and restarts as from power-up.
- Nibble corrections use 4-bit arithmetic; the +3 on a nibble <= 9 cannot overflow 4 bits.
- The shift register is 4*DIGITS+WIDTH bits wide.

Decomposition:
- Package counter_pkg:
  - conv_state_t enum {IDLE, SHIFT, DONE}.
  - Function bcd_adj3(nibble) implementing the add-3 correction.
- Sub-module bcd_seq_conv:
  - Ports: clk, rst, start, bin[WIDTH], busy, done, bcd.
  - Holds the FSM and shift register.
- The top holds the counter, snap, change detect and bcd_valid.

Test Plan (WIDTH=8, DIGITS=3):
- Reset release, en=0 → bcd=12'h000; busy high for 9 cycles; bcd_valid=1 from edge 10 onward.
- ld=1, v=8'd255, then en=0 → after 10 edges bcd=12'h255, bcd_valid=1; count=255 throughout.
- v=250 loaded, en=1, dir=1, sat=0 for 6 cycles → count 251..255, 0; wrap pulse exactly on the 255→0 edge. Final bcd=12'h000 after the trailing conversion, with each intermediate restart observed.
- count=255, en=1, dir=1, sat=1 → count holds at 255, wrap=0. Then dir=0 with count=0 and sat=1 → holds at 0.
- ld v=8'd99, then 3 edges later ld v=8'd128 mid-conversion → bcd becomes 12'h099 first, then 12'h128. bcd_valid stays 0 until the 128 conversion completes.
- Assert rst during SHIFT of v=200 → next edge: busy=0, bcd=0, count=0, bcd_valid=0. A new conversion completes with bcd=12'h000.
